// File: rtl/dmem_io_sequencer_pkg.sv
// Shared mux select codes, sequencer state encoding and small helpers for the
// DMEM load/run/dump sequencer.
package dmem_io_sequencer_pkg;

  localparam logic [1:0] MUX_CORE = 2'd0;
  localparam logic [1:0] MUX_LOAD = 2'd1;
  localparam logic [1:0] MUX_DUMP = 2'd2;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_LOAD    = 4'd1,
    ST_WRITE   = 4'd2,
    ST_KICK    = 4'd3,
    ST_RUN     = 4'd4,
    ST_RD_ADDR = 4'd5,
    ST_RD_WAIT = 4'd6,
    ST_RD_OUT  = 4'd7,
    ST_DONE    = 4'd8
  } state_e;

  function automatic logic is_busy(input state_e s);
    return !((s == ST_IDLE) || (s == ST_DONE));
  endfunction

endpackage

// File: rtl/dmem_addr_counter.sv
// Address pointer shared by the load and dump phases: sync clear, parallel
// load and increment enable, in that priority order.
module dmem_addr_counter #(
  parameter int unsigned ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_val,
  input  logic              inc,
  output logic [ADDR_W-1:0] cnt
);

  logic [ADDR_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)       cnt_d = '0;
    else if (load) cnt_d = load_val;
    else if (inc)  cnt_d = cnt_q + ADDR_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/dmem_io_sequencer.sv
// Streams a load image into DMEM, kicks the core, waits for END, then streams a
// DMEM window back out. All outputs come straight from flops.
module dmem_io_sequencer
  import dmem_io_sequencer_pkg::*;
#(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned LOAD_WORDS  = 1000,
  parameter int unsigned DUMP_BASE   = 0,
  parameter int unsigned DUMP_END    = 997,
  parameter int unsigned RUN_TIMEOUT = 20000
) (
  input  logic              clk,
  input  logic              RESET,
  input  logic              go,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        addr_mux_select,
  output logic              START,
  input  logic              END,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic              timeout_err
);

  localparam int unsigned TIMER_W = (RUN_TIMEOUT > 1) ? $clog2(RUN_TIMEOUT) : 1;

  state_e              state_q, state_d;
  logic [TIMER_W-1:0]  timer_q, timer_d;
  logic                in_ready_q, in_ready_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                mem_we_q, mem_we_d;
  logic [1:0]          mux_q, mux_d;
  logic                start_q, start_d;
  logic                out_valid_q, out_valid_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                timeout_q, timeout_d;

  logic                cnt_clr, cnt_load, cnt_inc;
  logic [ADDR_W-1:0]   ptr;

  dmem_addr_counter #(.ADDR_W(ADDR_W)) u_ptr (
    .clk      (clk),
    .rst      (RESET),
    .clr      (cnt_clr),
    .load     (cnt_load),
    .load_val (ADDR_W'(DUMP_BASE)),
    .inc      (cnt_inc),
    .cnt      (ptr)
  );

  // Next-state and next-output logic; outputs are computed for the state being entered.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    in_ready_d  = in_ready_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = 1'b0;
    mux_d       = mux_q;
    start_d     = 1'b0;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    done_d      = done_q;
    timeout_d   = timeout_q;
    cnt_clr     = 1'b0;
    cnt_load    = 1'b0;
    cnt_inc     = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (go) begin
          done_d    = 1'b0;
          timeout_d = 1'b0;
          cnt_clr   = 1'b1;
          if (LOAD_WORDS == 0) begin
            state_d = ST_KICK;
            mux_d   = MUX_CORE;
            start_d = 1'b1;
          end else begin
            state_d    = ST_LOAD;
            mux_d      = MUX_LOAD;
            in_ready_d = 1'b1;
          end
        end
      end
      ST_LOAD: begin
        if (in_valid && in_ready_q) begin
          mem_wdata_d = in_data;
          mem_addr_d  = ptr;
          mem_we_d    = 1'b1;
          in_ready_d  = 1'b0;
          state_d     = ST_WRITE;
        end
      end
      ST_WRITE: begin
        cnt_inc = 1'b1;
        if (32'(ptr) + 32'd1 == LOAD_WORDS) begin
          state_d = ST_KICK;
          mux_d   = MUX_CORE;
          start_d = 1'b1;
        end else begin
          state_d    = ST_LOAD;
          in_ready_d = 1'b1;
        end
      end
      ST_KICK: begin
        timer_d = '0;
        state_d = ST_RUN;
      end
      // END beats the timeout when both land in the same cycle.
      ST_RUN: begin
        timer_d = timer_q + TIMER_W'(1);
        if (END) begin
          cnt_load   = 1'b1;
          mem_addr_d = ADDR_W'(DUMP_BASE);
          mux_d      = MUX_DUMP;
          state_d    = ST_RD_ADDR;
        end else if (timer_q == TIMER_W'(RUN_TIMEOUT - 1)) begin
          timeout_d = 1'b1;
          done_d    = 1'b1;
          state_d   = ST_DONE;
        end
      end
      ST_RD_ADDR: begin
        if (32'(ptr) >= DUMP_END) begin
          mux_d   = MUX_CORE;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          state_d = ST_RD_WAIT;
        end
      end
      ST_RD_WAIT: begin
        out_data_d  = mem_rdata;
        out_valid_d = 1'b1;
        state_d     = ST_RD_OUT;
      end
      ST_RD_OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          cnt_inc     = 1'b1;
          mem_addr_d  = ptr + ADDR_W'(1);
          state_d     = ST_RD_ADDR;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = is_busy(state_d);
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      state_q     <= ST_IDLE;
      timer_q     <= '0;
      in_ready_q  <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      mux_q       <= MUX_CORE;
      start_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      in_ready_q  <= in_ready_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      mux_q       <= mux_d;
      start_q     <= start_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      timeout_q   <= timeout_d;
    end
  end

  assign in_ready        = in_ready_q;
  assign mem_addr        = mem_addr_q;
  assign mem_wdata       = mem_wdata_q;
  assign mem_we          = mem_we_q;
  assign addr_mux_select = mux_q;
  assign START           = start_q;
  assign out_valid       = out_valid_q;
  assign out_data        = out_data_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign timeout_err     = timeout_q;

endmodule

// File: tb/tb_dmem_io_sequencer.sv
// Randomized bench for dmem_io_sequencer: a DMEM + core model drives the main
// instance, a second instance covers empty-load, timeout and empty-dump cases.
module tb_dmem_io_sequencer;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;
  localparam int unsigned N_LOAD = 4;
  localparam int unsigned D_END  = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          go, in_valid, in_ready, mem_we, start, out_valid, out_ready;
  logic          busy, done, tmo;
  logic [DW-1:0] in_data, mem_wdata, out_data;
  logic [DW-1:0] mem_rdata = '0;
  logic [AW-1:0] mem_addr;
  logic [1:0]    mux;
  logic          core_end = 1'b0;

  logic          go_e, end_e;
  logic          in_ready_e, mem_we_e, start_e, out_valid_e, busy_e, done_e, tmo_e;
  logic [DW-1:0] mem_wdata_e, out_data_e;
  logic [AW-1:0] mem_addr_e;
  logic [1:0]    mux_e;

  dmem_io_sequencer #(
    .ADDR_W(AW), .DATA_W(DW), .LOAD_WORDS(N_LOAD),
    .DUMP_BASE(0), .DUMP_END(D_END), .RUN_TIMEOUT(64)
  ) u_dut (
    .clk(clk), .RESET(rst), .go(go), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .addr_mux_select(mux), .START(start), .END(core_end),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .busy(busy), .done(done), .timeout_err(tmo)
  );

  dmem_io_sequencer #(
    .ADDR_W(AW), .DATA_W(DW), .LOAD_WORDS(0),
    .DUMP_BASE(2), .DUMP_END(2), .RUN_TIMEOUT(16)
  ) u_edge (
    .clk(clk), .RESET(rst), .go(go_e), .in_valid(1'b0), .in_data(16'h0),
    .in_ready(in_ready_e), .mem_addr(mem_addr_e), .mem_wdata(mem_wdata_e), .mem_we(mem_we_e),
    .mem_rdata(16'h0), .addr_mux_select(mux_e), .START(start_e), .END(end_e),
    .out_valid(out_valid_e), .out_data(out_data_e), .out_ready(1'b1),
    .busy(busy_e), .done(done_e), .timeout_err(tmo_e)
  );

  // DMEM and core model: core raises END end_delay cycles after START and
  // leaves DMEM[i] = i + 100 + core_off as its result.
  logic [DW-1:0] mem [16] = '{default: '0};
  logic [DW-1:0] ld_words [N_LOAD];
  int            end_delay = 50;
  int            core_off  = 0;
  int            core_cnt  = 0;
  bit            core_busy = 1'b0;

  always @(posedge clk) begin
    if (start) begin
      core_end  <= 1'b0;
      core_cnt  <= end_delay;
      core_busy <= 1'b1;
    end else if (core_busy) begin
      if (core_cnt <= 1) begin
        core_end  <= 1'b1;
        core_busy <= 1'b0;
        for (int i = 0; i < 16; i++) mem[i] <= DW'(i + 100 + core_off);
      end else begin
        core_cnt <= core_cnt - 1;
      end
    end
    if (mem_we && mux == 2'd1) mem[mem_addr[3:0]] <= mem_wdata;
    mem_rdata <= mem[mem_addr[3:0]];
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One full sequence on the main instance, scored against a queue model.
  task automatic run_main(input bit rnd, input bit bp2, input bit spam);
    int wr_idx = 0, in_idx = 0, rd_idx = 0, n_start = 0, bp_left = 0, cyc = 0;
    bit bp_used = 1'b0, pend = 1'b0, fin = 1'b0;
    logic [DW-1:0] exp_q[$];
    for (int a = 0; a < int'(D_END); a++) exp_q.push_back(DW'(a + 100 + core_off));
    @(negedge clk); go = 1'b1;
    @(negedge clk); go = 1'b0;
    while (!fin && cyc < 2000) begin
      if (mem_we) begin
        if (wr_idx < int'(N_LOAD)) begin
          check_eq("wr_addr", 32'(mem_addr), wr_idx);
          check_eq("wr_data", 32'(mem_wdata), 32'(ld_words[wr_idx]));
          check_eq("wr_mux", 32'(mux), 1);
        end else check_eq("wr_count", wr_idx + 1, N_LOAD);
        wr_idx++;
      end
      if (start) begin
        n_start++;
        check_eq("start_after_load", wr_idx, N_LOAD);
      end
      if (pend) check_eq("ov_hold", 32'(out_valid), 1);
      if (done) begin
        fin = 1'b1;
      end else begin
        in_valid = (in_idx < int'(N_LOAD)) && (rnd ? ($urandom_range(0, 1) == 1) : 1'b1);
        in_data  = (in_idx < int'(N_LOAD)) ? ld_words[in_idx] : DW'($urandom);
        if (in_valid && in_ready) in_idx++;
        if (bp2 && out_valid && rd_idx == 1 && !bp_used) begin
          bp_used = 1'b1;
          bp_left = 5;
        end
        if (bp_left > 0) begin
          out_ready = 1'b0;
          bp_left--;
        end else out_ready = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
        pend = 1'b0;
        if (out_valid) begin
          if (rd_idx >= exp_q.size()) check_eq("dump_count", rd_idx + 1, exp_q.size());
          else if (out_ready) begin
            check_eq("dump_data", 32'(out_data), 32'(exp_q[rd_idx]));
            rd_idx++;
          end else begin
            check_eq("bp_hold", 32'(out_data), 32'(exp_q[rd_idx]));
            pend = 1'b1;
          end
        end
        go = spam && busy && ($urandom_range(0, 3) == 0);
        @(negedge clk);
        cyc++;
      end
    end
    go = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    if (!fin) check_eq("seq_budget", cyc, 0);
    check_eq("n_start", n_start, 1);
    check_eq("n_writes", wr_idx, N_LOAD);
    check_eq("n_dump", rd_idx, exp_q.size());
    check_eq("done_tmo", 32'(tmo), 0);
    check_eq("done_busy", 32'(busy), 0);
    check_eq("done_mux", 32'(mux), 0);
    repeat (2) @(negedge clk);
    check_eq("done_held", 32'(done), 1);
  endtask

  // One sequence on the edge instance: no load words, empty dump window.
  task automatic run_edge(input bit end_lvl, input int exp_run, input bit exp_tmo);
    int run_cyc = 0, n_start = 0, cyc = 0;
    bit fin = 1'b0, saw_ov = 1'b0, saw_ld = 1'b0, first = 1'b1;
    end_e = end_lvl;
    @(negedge clk); go_e = 1'b1;
    @(negedge clk); go_e = 1'b0;
    while (!fin && cyc < 200) begin
      if (first) begin
        check_eq("e_start_next", 32'(start_e), 1);
        check_eq("e_done_clr", 32'(done_e), 0);
        check_eq("e_tmo_clr", 32'(tmo_e), 0);
        first = 1'b0;
      end
      if (start_e) n_start++;
      else if (busy_e) run_cyc++;
      saw_ov |= out_valid_e;
      saw_ld |= mem_we_e | in_ready_e;
      if (done_e) fin = 1'b1;
      else begin
        go_e = busy_e && ($urandom_range(0, 2) == 0);
        @(negedge clk);
        cyc++;
      end
    end
    go_e = 1'b0;
    check_eq("e_fin", 32'(fin), 1);
    check_eq("e_run_cycles", run_cyc, exp_run);
    check_eq("e_tmo", 32'(tmo_e), 32'(exp_tmo));
    check_eq("e_start_cnt", n_start, 1);
    check_eq("e_no_out", 32'(saw_ov), 0);
    check_eq("e_no_load", 32'(saw_ld), 0);
  endtask

  task automatic check_reset_outs();
    check_eq("rst_ctl", 32'({in_ready, mem_we, start, out_valid, busy, done, tmo, mux}), 0);
    check_eq("rst_addr", 32'(mem_addr), 0);
    check_eq("rst_wdata", 32'(mem_wdata), 0);
    check_eq("rst_odata", 32'(out_data), 0);
    check_eq("rst_edge", 32'({in_ready_e, mem_we_e, start_e, out_valid_e, busy_e, done_e, tmo_e, mux_e}), 0);
  endtask

  initial begin
    rst = 1'b1; go = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    go_e = 1'b0; end_e = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outs();
    rst = 1'b0;

    ld_words[0] = 16'd10; ld_words[1] = 16'd20; ld_words[2] = 16'd30; ld_words[3] = 16'd40;
    end_delay = 50; core_off = 0;
    run_main(1'b0, 1'b1, 1'b0);

    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < int'(N_LOAD); k++) ld_words[k] = DW'($urandom);
      end_delay = $urandom_range(1, 60);
      core_off  = $urandom_range(0, 1000);
      run_main(1'b1, r[0], 1'b1);
    end

    // Abort mid-load with a 3-cycle reset, then a fresh sequence must restart at address 0.
    @(negedge clk); go = 1'b1;
    @(negedge clk); go = 1'b0; in_valid = 1'b1; in_data = 16'h1234;
    repeat (4) @(negedge clk);
    rst = 1'b1; in_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check_reset_outs();
    end
    rst = 1'b0;
    for (int k = 0; k < int'(N_LOAD); k++) ld_words[k] = DW'($urandom);
    end_delay = 20; core_off = 7;
    run_main(1'b1, 1'b0, 1'b0);

    run_edge(1'b0, 16, 1'b1);
    run_edge(1'b1, 2, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
